// File: rtl/vend_credit_controller.sv
// Coin-credit and vend controller: accumulates coins, vends when credit covers
// PRICE, returns change or a full refund, and holds the result for HOLD_CYCLES.
module vend_credit_controller #(
  parameter int PRICE       = 65,
  parameter int MAX_CREDIT  = 995,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_coin_5,
  input  logic        i_coin_10,
  input  logic        i_coin_25,
  input  logic        i_buy,
  input  logic        i_cancel,
  output logic [31:0] o_collected,
  output logic [31:0] o_change,
  output logic        o_dispense,
  output logic        o_coin_reject,
  output logic        o_short,
  output logic [1:0]  o_state
);

  localparam int TW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SHOW    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      credit_q, credit_d;
  logic [9:0]      change_q, change_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            dispense_q, dispense_d;
  logic            reject_q, reject_d;
  logic            short_q, short_d;

  logic [1:0]      coin_cnt;
  logic            any_coin;
  logic            valid_coin;
  logic [9:0]      coin_val;
  logic [10:0]     credit_sum;
  logic            coin_fits;
  logic            can_vend;
  logic            hold_done;

  // Coin decode: only a single asserted coin line carries a value.
  always_comb begin
    coin_cnt   = {1'b0, i_coin_5} + {1'b0, i_coin_10} + {1'b0, i_coin_25};
    any_coin   = i_coin_5 | i_coin_10 | i_coin_25;
    valid_coin = (coin_cnt == 2'd1);
    coin_val   = 10'd0;
    if (i_coin_5)  coin_val = 10'd5;
    if (i_coin_10) coin_val = 10'd10;
    if (i_coin_25) coin_val = 10'd25;
    // One extra bit so the overflow test itself can never wrap.
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits  = (credit_sum <= 11'(MAX_CREDIT));
    can_vend   = (credit_q >= 10'(PRICE));
    hold_done  = (timer_q == TW'(HOLD_CYCLES - 1));
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    credit_d   = credit_q;
    change_d   = change_q;
    timer_d    = timer_q;
    dispense_d = 1'b0;
    reject_d   = 1'b0;
    short_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_buy) begin
          short_d  = 1'b1;
          reject_d = any_coin;
        end else if (valid_coin) begin
          credit_d = coin_val;
          change_d = 10'd0;
          state_d  = S_COLLECT;
        end else if (any_coin) begin
          reject_d = 1'b1;
        end
      end

      S_COLLECT: begin
        if (i_cancel) begin
          change_d = credit_q;
          credit_d = 10'd0;
          timer_d  = '0;
          reject_d = any_coin;
          state_d  = S_SHOW;
        end else if (i_buy && can_vend) begin
          dispense_d = 1'b1;
          change_d   = credit_q - 10'(PRICE);
          credit_d   = 10'd0;
          timer_d    = '0;
          reject_d   = any_coin;
          state_d    = S_SHOW;
        end else begin
          // A refused buy does not consume the cycle; a coin is still judged.
          short_d = i_buy;
          if (valid_coin && coin_fits) begin
            credit_d = credit_sum[9:0];
          end else if (any_coin) begin
            reject_d = 1'b1;
          end
        end
      end

      S_SHOW: begin
        reject_d = any_coin;
        if (hold_done) begin
          timer_d  = '0;
          change_d = 10'd0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      credit_q   <= 10'd0;
      change_q   <= 10'd0;
      timer_q    <= '0;
      dispense_q <= 1'b0;
      reject_q   <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      timer_q    <= timer_d;
      dispense_q <= dispense_d;
      reject_q   <= reject_d;
      short_q    <= short_d;
    end
  end

  assign o_collected   = {22'd0, credit_q};
  assign o_change      = {22'd0, change_q};
  assign o_dispense    = dispense_q;
  assign o_coin_reject = reject_q;
  assign o_short       = short_q;
  assign o_state       = state_q;

endmodule
